// File: rtl/ram_stream_pkg.sv
// Shared definitions for the RAM stream reader: default widths, FSM encoding, byte enables.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_stream_pkg;

    localparam int DFLT_ADDR_W     = 16;
    localparam int DFLT_DATA_W     = 32;
    localparam int DFLT_LEN_W      = 16;
    localparam int DFLT_FIFO_DEPTH = 8;

    // Every read fetches a full 32-bit word.
    localparam logic [3:0] BE_ALL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ram_stream_reader_if.sv
// Avalon-MM read port plus the outgoing valid/ready word stream of the RAM reader.
// Latency: n/a (wires only).
// Backpressure: avm_waitrequest stalls requests; out_ready stalls the stream.
interface ram_stream_reader_if
    import ram_stream_pkg::*;
#(
    parameter int ADDR_W = DFLT_ADDR_W,
    parameter int DATA_W = DFLT_DATA_W
);

    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    // Reader side: issues reads, produces the stream.
    modport master (
        output avm_address, avm_read, avm_byteenable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output out_data, out_valid, out_last,
        input  out_ready
    );

    // RAM slave / stream consumer side.
    modport slave (
        input  avm_address, avm_read, avm_byteenable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  out_data, out_valid, out_last,
        output out_ready
    );

endinterface

// File: rtl/ram_stream_fifo.sv
// Synchronous FIFO buffering returned read data ahead of the stream consumer.
// Latency: 1 cycle push-to-dout; an empty FIFO pushed and popped together passes din straight through.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module ram_stream_fifo
    import ram_stream_pkg::*;
#(
    parameter int DEPTH = DFLT_FIFO_DEPTH,
    parameter int WIDTH = DFLT_DATA_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             bypass;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign bypass  = empty & push & pop;
    assign do_push = push & (~full | pop) & ~bypass;
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? din : mem[rd_ptr];

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at a power-of-2 depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Avalon-MM read master streaming cfg_len words from cfg_base out on a valid/ready port.
// Latency: first out_valid 2 cycles after the first accepted read (slave latency 1); 1 word/cycle sustained.
// Backpressure: reads issue only while outstanding + buffered words < FIFO_DEPTH, so out_ready=0 stalls requests.
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int ADDR_W     = DFLT_ADDR_W,
    parameter int DATA_W     = DFLT_DATA_W,
    parameter int LEN_W      = DFLT_LEN_W,
    parameter int FIFO_DEPTH = DFLT_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              busy,
    output logic              done,
    ram_stream_reader_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              read_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  req_left;
    logic [LEN_W-1:0]  pop_cnt;
    logic [CNT_W-1:0]  outstanding;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_dout;
    logic [CNT_W-1:0]  fifo_count;

    logic              accepted;
    logic              rdv_eff;
    logic              credit_ok;
    logic              last_pop;
    logic              at_last_word;
    logic [CNT_W-1:0]  outstanding_nxt;
    logic [CNT_W-1:0]  count_nxt;

    assign accepted     = read_q & ~bus.avm_waitrequest;
    // A readdatavalid with nothing in flight (e.g. left over from before a reset) is dropped.
    assign rdv_eff      = bus.avm_readdatavalid & (outstanding != '0);
    assign fifo_pop     = ~fifo_empty & bus.out_ready;
    assign fifo_push    = rdv_eff & (~fifo_full | fifo_pop);
    assign at_last_word = (pop_cnt == len_q - LEN_W'(1));
    assign last_pop     = fifo_pop & at_last_word;

    // Credit is judged on next-cycle occupancy so a raised request always has a guaranteed slot.
    assign outstanding_nxt = outstanding + CNT_W'(accepted) - CNT_W'(rdv_eff);
    assign count_nxt       = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    assign credit_ok       = ({1'b0, outstanding_nxt} + {1'b0, count_nxt}) < (CNT_W+1)'(FIFO_DEPTH);

    assign bus.avm_address    = addr_q;
    assign bus.avm_read       = read_q;
    assign bus.avm_byteenable = BE_ALL;
    assign bus.out_valid      = ~fifo_empty;
    assign bus.out_data       = fifo_empty ? '0 : fifo_dout;
    assign bus.out_last       = ~fifo_empty & at_last_word;

    ram_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (bus.avm_readdata),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Transfer FSM with registered request, address, counters and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            read_q      <= 1'b0;
            len_q       <= '0;
            req_left    <= '0;
            pop_cnt     <= '0;
            outstanding <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done        <= 1'b0;
            outstanding <= outstanding_nxt;
            if (accepted) begin
                addr_q   <= addr_q + ADDR_W'(1);
                req_left <= req_left - LEN_W'(1);
            end
            if (fifo_pop) begin
                pop_cnt <= pop_cnt + LEN_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        addr_q   <= cfg_base;
                        len_q    <= cfg_len;
                        req_left <= cfg_len;
                        pop_cnt  <= '0;
                        busy     <= 1'b1;
                        if (cfg_len == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= ST_READ;
                            read_q <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (accepted && (req_left == LEN_W'(1))) begin
                        state  <= ST_DRAIN;
                        read_q <= 1'b0;
                    end else if (read_q && bus.avm_waitrequest) begin
                        read_q <= 1'b1;
                    end else begin
                        read_q <= credit_ok;
                    end
                end
                ST_DRAIN: begin
                    if (last_pop) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a latency-1 RAM slave model.
// Latency: n/a.
// Backpressure: drives waitrequest and out_ready per test.
module tb_ram_stream_reader;

    logic        clk;
    logic        reset_n;
    logic        cfg_start;
    logic [15:0] cfg_base;
    logic [15:0] cfg_len;
    logic        busy;
    logic        done;

    ram_stream_reader_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    ram_stream_reader #(
        .ADDR_W     (16),
        .DATA_W     (32),
        .LEN_W      (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_start (cfg_start),
        .cfg_base  (cfg_base),
        .cfg_len   (cfg_len),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    localparam logic [15:0] T1_ADDR [4] = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    localparam logic [31:0] T1_DATA [4] = '{32'hBEFF0010, 32'hBEFE0011, 32'hBEFD0012, 32'hBEFC0013};
    localparam logic [15:0] T3_ADDR [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    int n_chk  = 0;
    int n_pass = 0;

    // Monitor state (written only by the monitor process).
    logic [15:0] acc_addr [$];
    int          acc_cyc  [$];
    logic [31:0] got_data [$];
    bit          got_last [$];
    int          pop_cyc  [$];
    int          cyc     = 0;
    int          n_rdcyc = 0;
    int          n_done  = 0;
    int          n_viol  = 0;
    int          n_stall = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_addr  = '0;

    function automatic logic [31:0] ram_word(input logic [15:0] a);
        return {a ^ 16'hBEEF, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM slave: fixed read latency of one cycle.
    always @(posedge clk) begin
        bus.avm_readdatavalid <= 1'b0;
        if (bus.avm_read && !bus.avm_waitrequest) begin
            bus.avm_readdatavalid <= 1'b1;
            bus.avm_readdata      <= ram_word(bus.avm_address);
        end
    end

    // Monitor samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            if (bus.avm_read) n_rdcyc++;
            if (bus.avm_read && bus.avm_waitrequest) n_stall++;
            if (prev_stall && (!bus.avm_read || bus.avm_address != prev_addr)) n_viol++;
            prev_stall = bus.avm_read && bus.avm_waitrequest;
            prev_addr  = bus.avm_address;
            if (bus.avm_read && !bus.avm_waitrequest) begin
                acc_addr.push_back(bus.avm_address);
                acc_cyc.push_back(cyc);
            end
            if (bus.out_valid && bus.out_ready) begin
                got_data.push_back(bus.out_data);
                got_last.push_back(bus.out_last);
                pop_cyc.push_back(cyc);
            end
            if (done) n_done++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic start(input logic [15:0] base, input logic [15:0] len);
        @(posedge clk); #1;
        cfg_base  = base;
        cfg_len   = len;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        check("busy_on", busy, 1);
    endtask

    task automatic finish_run(input bit rnd, input int mid_at);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (rnd) bus.avm_waitrequest = 1'($urandom_range(0, 1));
            if (i == mid_at) begin
                cfg_base  = 16'h0500;
                cfg_len   = 16'd3;
                cfg_start = 1'b1;
            end else begin
                cfg_start = 1'b0;
            end
        end
        cfg_start           = 1'b0;
        bus.avm_waitrequest = 1'b0;
        check("done_seen", seen, 1);
        @(posedge clk); #1;
        check("busy_off", busy, 0);
        check("done_pulse", done, 0);
    endtask

    initial begin
        int s_acc, s_pop, d0, r0, v0, st0;
        reset_n             = 1'b1;
        cfg_start           = 1'b0;
        cfg_base            = '0;
        cfg_len             = '0;
        bus.out_ready       = 1'b0;
        bus.avm_waitrequest = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_read", bus.avm_read, 0);
        check("rst_addr", bus.avm_address, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_last", bus.out_last, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_be", bus.avm_byteenable, 32'hF);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // 1: basic four-word read, no stalls.
        bus.out_ready = 1'b1;
        s_acc = acc_addr.size(); s_pop = got_data.size(); d0 = n_done;
        start(16'h0010, 16'd4);
        finish_run(1'b0, -1);
        check("t1_nacc", acc_addr.size() - s_acc, 4);
        check("t1_nword", got_data.size() - s_pop, 4);
        if (acc_addr.size() >= s_acc + 4 && got_data.size() >= s_pop + 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t1_addr", acc_addr[s_acc+i], T1_ADDR[i]);
                check("t1_data", got_data[s_pop+i], T1_DATA[i]);
                check("t1_last", got_last[s_pop+i], (i == 3));
            end
            check("t1_latency", pop_cyc[s_pop] - acc_cyc[s_acc], 2);
            check("t1_rate", pop_cyc[s_pop+3] - pop_cyc[s_pop], 3);
        end
        check("t1_done", n_done - d0, 1);

        // 2: zero-length transfer.
        r0 = n_rdcyc; d0 = n_done; s_pop = got_data.size();
        start(16'h0020, 16'd0);
        finish_run(1'b0, -1);
        check("t2_reads", n_rdcyc - r0, 0);
        check("t2_done", n_done - d0, 1);
        check("t2_words", got_data.size() - s_pop, 0);

        // 3: address wrap at the top of the space.
        s_acc = acc_addr.size(); s_pop = got_data.size();
        start(16'hFFFE, 16'd4);
        finish_run(1'b0, -1);
        check("t3_nacc", acc_addr.size() - s_acc, 4);
        if (acc_addr.size() >= s_acc + 4 && got_data.size() >= s_pop + 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t3_addr", acc_addr[s_acc+i], T3_ADDR[i]);
                check("t3_data", got_data[s_pop+i], ram_word(T3_ADDR[i]));
            end
        end

        // 4: stream held off; reads cap at FIFO depth, then all words drain intact.
        bus.out_ready = 1'b0;
        s_acc = acc_addr.size(); s_pop = got_data.size();
        start(16'h0040, 16'd20);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
        end
        check("t4_acc_capped", acc_addr.size() - s_acc, 8);
        check("t4_read_low", bus.avm_read, 0);
        check("t4_valid_held", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        finish_run(1'b0, -1);
        check("t4_nacc", acc_addr.size() - s_acc, 20);
        check("t4_nword", got_data.size() - s_pop, 20);
        if (got_data.size() >= s_pop + 20) begin
            for (int i = 0; i < 20; i++) begin
                check("t4_data", got_data[s_pop+i], ram_word(16'(16'h0040 + i)));
            end
            check("t4_last", got_last[s_pop+19], 1);
            check("t4_last_early", got_last[s_pop+18], 0);
        end

        // 5: random waitrequest, stray start mid-transfer.
        s_acc = acc_addr.size(); s_pop = got_data.size();
        d0 = n_done; v0 = n_viol; st0 = n_stall;
        start(16'h0300, 16'd12);
        finish_run(1'b1, 4);
        check("t5_nacc", acc_addr.size() - s_acc, 12);
        check("t5_nword", got_data.size() - s_pop, 12);
        if (got_data.size() >= s_pop + 12) begin
            for (int i = 0; i < 12; i++) begin
                check("t5_data", got_data[s_pop+i], ram_word(16'(16'h0300 + i)));
            end
        end
        check("t5_done", n_done - d0, 1);
        check("t5_stall_stable", n_viol - v0, 0);
        check("t5_stalled", (n_stall - st0) > 0, 1);

        // 6: reset after three accepted reads, then a fresh short transfer.
        s_acc = acc_addr.size();
        start(16'h0200, 16'd10);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (acc_addr.size() - s_acc >= 3) break;
        end
        check("t6_acc3", acc_addr.size() - s_acc, 3);
        reset_n = 1'b0;
        #1;
        check("t6_rst_read", bus.avm_read, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_valid", bus.out_valid, 0);
        check("t6_rst_data", bus.out_data, 0);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        check("t6_stale_drop", bus.out_valid, 0);
        s_acc = acc_addr.size(); s_pop = got_data.size();
        start(16'h0100, 16'd2);
        finish_run(1'b0, -1);
        check("t6_nword", got_data.size() - s_pop, 2);
        if (got_data.size() >= s_pop + 2) begin
            check("t6_data0", got_data[s_pop], 32'hBFEF0100);
            check("t6_data1", got_data[s_pop+1], 32'hBFEE0101);
            check("t6_last", got_last[s_pop+1], 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
